// File: rtl/axis_fir_tf.sv
// Transposed-form FIR filter with AXI-Stream sample ports.
// Each processing element multiplies the incoming sample by its coefficient
// and adds the partial sum from the next element. The head of the chain is
// rounded, saturated and held in a one-deep output register.
module axis_fir_tf #(
  parameter int N_TAPS    = 8,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15,
  parameter int OUT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        coef_we,
  input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]    coef_wdata,
  input  logic signed [DATA_W-1:0]    s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic signed [OUT_W-1:0]     m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        sat_flag
);

  // Half an output LSB; zero when no scaling is applied.
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'((64'd1 << OUT_SHIFT) >> 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [COEF_W-1:0] h     [N_TAPS];
  logic signed [ACC_W-1:0]  p     [N_TAPS];
  logic signed [ACC_W-1:0]  p_nxt [N_TAPS];

  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  y;
  logic signed [ACC_W-1:0]  r;
  logic signed [OUT_W-1:0]  y_sat;
  logic                     sat_hi;
  logic                     sat_lo;
  logic                     acc;

  // A new sample may enter whenever the output slot is free or draining,
  // but never while history is being cleared.
  assign s_axis_tready = !clr && (!m_axis_tvalid || m_axis_tready);
  assign acc           = s_axis_tvalid && s_axis_tready;

  assign x_ext = ACC_W'(s_axis_tdata);

  // Next partial sums of the transposed chain, built from the current ones.
  // NOTE: every element of p_nxt is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < N_TAPS - 1; k++) begin
      p_nxt[k] = x_ext * ACC_W'(h[k]) + p[k+1];
    end
    p_nxt[N_TAPS-1] = x_ext * ACC_W'(h[N_TAPS-1]);
  end

  // The head of the chain is the full convolution for the current sample.
  assign y = p_nxt[0];
  assign r = (y + RND) >>> OUT_SHIFT;

  // Clamp the rounded value into the output range.
  always_comb begin
    sat_hi = (r > OUT_MAX);
    sat_lo = (r < OUT_MIN);
    if (sat_hi) begin
      y_sat = OUT_MAX[OUT_W-1:0];
    end else if (sat_lo) begin
      y_sat = OUT_MIN[OUT_W-1:0];
    end else begin
      y_sat = r[OUT_W-1:0];
    end
  end

  // Coefficient storage; writes apply from the next accepted sample onwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the coefficient array is explicitly cleared on reset because the
      // filter must produce zeros until software programs it.
      for (int k = 0; k < N_TAPS; k++) begin
        h[k] <= '0;
      end
    end else if (coef_we && (32'(coef_addr) < N_TAPS)) begin
      h[coef_addr] <= coef_wdata;
    end
  end

  // Partial-sum chain and output register; clear wins over a new sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      for (int k = 0; k < N_TAPS; k++) begin
        p[k] <= '0;
      end
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sat_flag      <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < N_TAPS; k++) begin
        p[k] <= '0;
      end
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sat_flag      <= 1'b0;
    end else if (acc) begin
      for (int k = 0; k < N_TAPS; k++) begin
        p[k] <= p_nxt[k];
      end
      m_axis_tdata  <= y_sat;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast;
      if (sat_hi || sat_lo) begin
        sat_flag <= 1'b1;
      end
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_fir_tf.sv
// Directed self-checking bench for axis_fir_tf. Three instances share one
// stimulus: 8 taps unscaled (a), 8 taps with 15-bit scaling (b), and
// 6 taps unscaled (c) for the out-of-range coefficient address case.
module tb_axis_fir_tf;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [15:0] coef_wdata = '0;
  logic signed [15:0] s_tdata = '0;
  logic               s_tvalid = 1'b0;
  logic               s_tlast = 1'b0;
  logic               m_tready = 1'b1;

  logic               a_tready, a_tvalid, a_tlast, a_sat;
  logic signed [15:0] a_tdata;
  logic               b_tready, b_tvalid, b_tlast, b_sat;
  logic signed [15:0] b_tdata;
  logic               c_tready, c_tvalid, c_tlast, c_sat;
  logic signed [15:0] c_tdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_fir_tf #(.N_TAPS(8), .OUT_SHIFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(a_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(a_tdata),
    .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(a_tlast),
    .sat_flag(a_sat));

  axis_fir_tf #(.N_TAPS(8), .OUT_SHIFT(15)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(b_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(b_tdata),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(b_tlast),
    .sat_flag(b_sat));

  axis_fir_tf #(.N_TAPS(6), .OUT_SHIFT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(c_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(c_tdata),
    .m_axis_tvalid(c_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(c_tlast),
    .sat_flag(c_sat));

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = addr[2:0];
    coef_wdata = val[15:0];
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Present one sample for one cycle (accepted when the output is free).
  task automatic push(input int x, input bit last);
    s_tvalid = 1'b1;
    s_tdata  = x[15:0];
    s_tlast  = last;
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int e_a [10];
    int e_c [10];
    int xs2 [4];
    int e_b [4];
    logic [0:15] rpat;
    int rx_data [16];
    logic rx_last [16];
    int ni, nrx;
    logic exp_mv, accd;

    // Reset values
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_tvalid", a_tvalid, 0);
    check("rst_tdata", a_tdata, 0);
    check("rst_tlast", a_tlast, 0);
    check("rst_sat", a_sat, 0);
    check("rst_tready", a_tready, 1);

    // Impulse response, h = 1..8; the 6-tap instance ignores addresses 6 and 7
    for (int k = 0; k < 8; k++) set_coef(k, k + 1);
    do_clr();
    e_a = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
    e_c = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      push((i == 0) ? 1 : 0, 1'b0);
      check($sformatf("imp_a[%0d]", i), a_tdata, e_a[i]);
      check($sformatf("imp_c[%0d]", i), c_tdata, e_c[i]);
    end
    check("imp_tvalid", a_tvalid, 1);
    check("imp_sat", a_sat, 0);

    // Round half toward +inf with h[0] = 0.5
    set_coef(0, 16384);
    for (int k = 1; k < 8; k++) set_coef(k, 0);
    do_clr();
    xs2 = '{3, -3, 1, -1};
    e_b = '{2, -1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      push(xs2[i], 1'b0);
      check($sformatf("round_b[%0d]", i), b_tdata, e_b[i]);
    end

    // Positive and negative saturation
    for (int k = 0; k < 8; k++) set_coef(k, 32767);
    do_clr();
    push(32767, 1'b0);
    check("satp_b0", b_tdata, 32766);
    check("satp_flag0", b_sat, 0);
    push(32767, 1'b0);
    check("satp_b1", b_tdata, 32767);
    check("satp_flag1", b_sat, 1);
    push(32767, 1'b0);
    check("satp_b2", b_tdata, 32767);
    do_clr();
    check("satn_clr_flag", b_sat, 0);
    push(-32768, 1'b0);
    check("satn_b0", b_tdata, -32767);
    push(-32768, 1'b0);
    check("satn_b1", b_tdata, -32768);
    check("satn_flag", b_sat, 1);

    // Backpressure: impulse stream, tlast on input 5
    for (int k = 0; k < 8; k++) set_coef(k, k + 1);
    do_clr();
    rpat   = 16'b1001_1001_0110_1101;
    ni     = 0;
    nrx    = 0;
    exp_mv = 1'b0;
    for (int c = 0; c < 64 && nrx < 8; c++) begin
      m_tready = (ni < 8) ? rpat[c % 16] : 1'b1;
      s_tvalid = (ni < 8);
      s_tdata  = (ni == 0) ? 16'sd1 : 16'sd0;
      s_tlast  = (ni == 4);
      #1;
      check("bp_tvalid", a_tvalid, exp_mv);
      check("bp_s_tready", a_tready, !exp_mv || m_tready);
      if (a_tvalid && m_tready && nrx < 16) begin
        rx_data[nrx] = a_tdata;
        rx_last[nrx] = a_tlast;
        nrx++;
      end
      accd = s_tvalid && (!exp_mv || m_tready);
      if (accd) ni++;
      exp_mv = accd ? 1'b1 : (m_tready ? 1'b0 : exp_mv);
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    check("bp_count", nrx, 8);
    for (int i = 0; i < 8 && i < nrx; i++) begin
      check($sformatf("bp_data[%0d]", i), rx_data[i], i + 1);
      check($sformatf("bp_last[%0d]", i), rx_last[i], (i == 4) ? 1 : 0);
    end

    // Clear mid-stream: sample presented with clr is discarded, sat cleared
    do_clr();
    push(32767, 1'b0);
    check("clr_pre0", a_tdata, 32767);
    check("clr_pre_flag0", a_sat, 0);
    push(32767, 1'b0);
    check("clr_pre1", a_tdata, 32767);
    check("clr_pre_flag1", a_sat, 1);
    clr      = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 16'sd5;
    s_tlast  = 1'b1;
    #1;
    check("clr_s_tready", a_tready, 0);
    tick();
    clr      = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("clr_tvalid", a_tvalid, 0);
    check("clr_sat", a_sat, 0);
    check("clr_tlast", a_tlast, 0);
    for (int i = 0; i < 9; i++) begin
      push((i == 0) ? 1 : 0, 1'b0);
      check($sformatf("clr_imp[%0d]", i), a_tdata, (i < 8) ? i + 1 : 0);
    end

    // Coefficient write in the same cycle as an accepted sample
    do_clr();
    coef_we    = 1'b1;
    coef_addr  = 3'd0;
    coef_wdata = 16'sd5;
    push(1, 1'b0);
    coef_we    = 1'b0;
    check("cw_same", a_tdata, 1);
    for (int i = 1; i < 8; i++) begin
      push(0, 1'b0);
      check($sformatf("cw_tail[%0d]", i), a_tdata, i + 1);
    end
    push(1, 1'b0);
    check("cw_new", a_tdata, 5);

    // Reset with an output held under backpressure drops it and zeroes h
    m_tready = 1'b0;
    push(0, 1'b0);
    tick();
    check("rst_hold_tvalid", a_tvalid, 1);
    check("rst_hold_s_tready", a_tready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_tvalid", a_tvalid, 0);
    check("rst_mid_tdata", a_tdata, 0);
    m_tready = 1'b1;
    push(1, 1'b1);
    check("rst_coef_zero", a_tdata, 0);
    check("rst_post_tvalid", a_tvalid, 1);
    check("rst_post_tlast", a_tlast, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
